// File: rtl/param_register_file.sv
// General-purpose register bank: byte-enabled synchronous write, two registered
// read ports with optional same-cycle write forwarding and optional hardwired-zero r0.
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG0  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wAddr,
  input  logic [DATA_WIDTH-1:0]   wData,
  input  logic [DATA_WIDTH/8-1:0] wBe,
  input  logic [ADDR_WIDTH-1:0]   rAddr0,
  input  logic [ADDR_WIDTH-1:0]   rAddr1,
  output logic [DATA_WIDTH-1:0]   rData0,
  output logic [DATA_WIDTH-1:0]   rData1
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en_p0;
  logic [DATA_WIDTH-1:0] wr_val_p0;
  logic [DATA_WIDTH-1:0] rd0_p0;
  logic [DATA_WIDTH-1:0] rd1_p0;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [NBYTES-1:0]     be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Stage p0: write merge and read selection, all combinational from the inputs
  always_comb begin
    wr_en_p0  = we && !((ZERO_REG0 != 0) && (wAddr == '0));
    wr_val_p0 = merge_bytes(mem[wAddr], wData, wBe);

    rd0_p0 = mem[rAddr0];
    if ((BYPASS != 0) && wr_en_p0 && (wAddr == rAddr0)) rd0_p0 = wr_val_p0;
    if ((ZERO_REG0 != 0) && (rAddr0 == '0)) rd0_p0 = '0;

    rd1_p0 = mem[rAddr1];
    if ((BYPASS != 0) && wr_en_p0 && (wAddr == rAddr1)) rd1_p0 = wr_val_p0;
    if ((ZERO_REG0 != 0) && (rAddr1 == '0)) rd1_p0 = '0;
  end

  // Stage p1: register bank update and registered read outputs
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rData0 <= '0;
      rData1 <= '0;
    end else begin
      if (wr_en_p0) mem[wAddr] <= wr_val_p0;
      rData0 <= rd0_p0;
      rData1 <= rd1_p0;
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: three instances (forwarding,
// no forwarding, hardwired-zero r0) share one stimulus stream.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        reset, clr, we;
  logic [2:0]  wAddr, rAddr0, rAddr1;
  logic [31:0] wData;
  logic [3:0]  wBe;
  logic [31:0] a_r0, a_r1, b_r0, b_r1, z_r0, z_r1;

  always #5 clk = ~clk;

  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG0(0)) u_a (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
    .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(a_r0), .rData1(a_r1));
  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG0(0)) u_b (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
    .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(b_r0), .rData1(b_r1));
  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG0(1)) u_z (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
    .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(z_r0), .rData1(z_r1));

  typedef struct {
    int          due;
    int          dut;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cnt = 0;
  int   checks = 0;
  int   fails = 0;
  bit   done = 1'b0;

  always @(posedge clk) cnt <= cnt + 1;

  // Expected value for one DUT/port, due after the next rising edge
  task automatic expect_val(input int dut, input int port, input logic [31:0] val, input string name);
    exp_t e;
    e.due = cnt + 1; e.dut = dut; e.port = port; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_all(input int port, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] vz, input string name);
    expect_val(0, port, va, name);
    expect_val(1, port, vb, name);
    expect_val(2, port, vz, name);
  endtask

  task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [2:0] ra0, input logic [2:0] ra1);
    reset = r; clr = c; we = w; wAddr = wa; wData = wd; wBe = be; rAddr0 = ra0; rAddr1 = ra1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_out(input int dut, input int port);
    case (dut)
      0:       return (port == 0) ? a_r0 : a_r1;
      1:       return (port == 0) ? b_r0 : b_r1;
      default: return (port == 0) ? z_r0 : z_r1;
    endcase
  endfunction

  // Monitor: compare everything due at this edge, away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cnt) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = dut_out(e.dut, e.port);
        checks++;
        if (e.due != cnt || got !== e.val) begin
          fails++;
          $display("FAIL %s dut%0d port%0d cycle %0d: got 0x%08h, expected 0x%08h",
                   e.name, e.dut, e.port, cnt, got, e.val);
        end
      end
      if (done || cnt > 2000) begin
        if (!done) begin
          fails++;
          $display("FAIL timeout: stimulus did not complete by cycle %0d", cnt);
        end
        if (sb.size() != 0) begin
          fails += sb.size();
          $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end

  logic [31:0] vals [8];

  initial begin
    vals[0] = 32'hffffffff; vals[1] = 32'h11111111; vals[2] = 32'h12345678; vals[3] = 32'h13579bdf;
    vals[4] = 32'habcd1234; vals[5] = 32'hef126793; vals[6] = 32'h98765432; vals[7] = 32'h2468acde;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 2; i++) begin
      expect_all(0, 0, 0, 0, "reset_r0");
      expect_all(1, 0, 0, 0, "reset_r1");
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 5, 7);
    expect_all(0, 0, 0, 0, "idle_after_reset_r0");
    expect_all(1, 0, 0, 0, "idle_after_reset_r1");
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 3'(i), vals[i], 4'hf, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      expect_all(0, vals[i], vals[i], (i == 0) ? 32'h0 : vals[i], "sweep_r0");
      expect_all(1, vals[7-i], vals[7-i], (i == 7) ? 32'h0 : vals[7-i], "sweep_r1");
      tick();
    end

    drive(0, 0, 1, 3, 32'haaaaaaaa, 4'b0101, 3, 1);
    expect_all(0, 32'h13aa9baa, 32'h13579bdf, 32'h13aa9baa, "byte_en_same_cycle");
    tick();
    drive(0, 0, 1, 3, 32'hffffffff, 4'b0000, 3, 3);
    expect_all(0, 32'h13aa9baa, 32'h13aa9baa, 32'h13aa9baa, "byte_en_readback");
    expect_all(1, 32'h13aa9baa, 32'h13aa9baa, 32'h13aa9baa, "be_zero_bypass");
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    expect_all(1, 32'h13aa9baa, 32'h13aa9baa, 32'h13aa9baa, "be_zero_unchanged");
    tick();

    drive(0, 0, 1, 2, 32'hdeadbeef, 4'hf, 2, 4);
    expect_all(0, 32'hdeadbeef, 32'h12345678, 32'hdeadbeef, "forward_full");
    expect_all(1, 32'habcd1234, 32'habcd1234, 32'habcd1234, "forward_other_port");
    tick();
    drive(0, 0, 0, 0, 0, 0, 2, 2);
    expect_all(0, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef, "forward_next_cycle");
    tick();
    drive(0, 0, 1, 5, 32'h00000000, 4'b1000, 4, 5);
    expect_all(1, 32'h00126793, 32'hef126793, 32'h00126793, "forward_partial");
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 6);
    expect_all(0, 32'h00126793, 32'h00126793, 32'h00126793, "partial_readback");
    expect_all(1, 32'h98765432, 32'h98765432, 32'h98765432, "reg6_readback");
    tick();

    drive(0, 1, 1, 4, 32'h55555555, 4'hf, 4, 2);
    expect_all(0, 0, 0, 0, "clr_beats_we_r0");
    expect_all(1, 0, 0, 0, "clr_beats_we_r1");
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 7);
    expect_all(0, 0, 0, 0, "clr_reg4");
    expect_all(1, 0, 0, 0, "clr_reg7");
    tick();

    drive(0, 0, 1, 4, 32'h11223344, 4'hf, 0, 0);
    tick();
    drive(0, 0, 1, 6, 32'hcafef00d, 4'hf, 4, 0);
    expect_all(0, 32'h11223344, 32'h11223344, 32'h11223344, "prefill_reg4");
    tick();
    drive(1, 1, 1, 4, 32'h55555555, 4'hf, 4, 6);
    expect_all(0, 0, 0, 0, "reset_beats_clr_we_r0");
    expect_all(1, 0, 0, 0, "reset_beats_clr_we_r1");
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 6);
    expect_all(0, 0, 0, 0, "reset_reg4");
    expect_all(1, 0, 0, 0, "reset_reg6");
    tick();

    drive(0, 0, 1, 0, 32'hffffffff, 4'hf, 0, 0);
    expect_all(0, 32'hffffffff, 32'h00000000, 32'h00000000, "zero_reg_write_r0");
    expect_all(1, 32'hffffffff, 32'h00000000, 32'h00000000, "zero_reg_write_r1");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_all(0, 32'hffffffff, 32'hffffffff, 32'h00000000, "zero_reg_later_r0");
    expect_all(1, 32'hffffffff, 32'hffffffff, 32'h00000000, "zero_reg_later_r1");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    expect_val(2, 0, 32'h0, "zero_reg_still_zero");
    tick();

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    done = 1'b1;
  end

endmodule
